// File: rtl/line_fill_memory_if.sv
// rtl/line_fill_memory_if.sv - request/response bundle between a cache fill engine and line_fill_memory
interface line_fill_memory_if #(
  parameter int ADDR_W = 15
);
  logic              req;
  logic              reqWrite;
  logic [ADDR_W-1:0] reqAddress;
  logic [31:0]       writeData;
  logic              ready;
  logic [127:0]      lineOut;
  logic              lineValid;
  logic              writeDone;

  modport master (
    output req, reqWrite, reqAddress, writeData,
    input  ready, lineOut, lineValid, writeDone
  );

  modport slave (
    input  req, reqWrite, reqAddress, writeData,
    output ready, lineOut, lineValid, writeDone
  );
endinterface

// File: rtl/line_fill_memory.sv
// rtl/line_fill_memory.sv - fixed-latency line-read / word-write main memory responder
// Optional: LINE_FILL_MEMORY_PATTERN_INIT_EN presets mem[i] = i at time zero.
module line_fill_memory #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 15
) (
  input  logic              clock,
  input  logic              reset,
  line_fill_memory_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [127:0]      line_q;
  logic [31:0]       mem [DEPTH];
  logic              accept;
  logic              access;
  logic [ADDR_W-3:0] base;

  // RESP counts as idle so a requester holding req is taken back-to-back
  assign accept = bus.req && (state_q != ST_BUSY);
  assign access = (state_q == ST_BUSY) && (count_q == 4'd0);
  assign base   = addr_q[ADDR_W-1:2];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      state_d = ST_BUSY;
      count_d = CNT_LOAD;
      write_d = bus.reqWrite;
      addr_d  = bus.reqWrite ? bus.reqAddress : {bus.reqAddress[ADDR_W-1:2], 2'b00};
      wdata_d = bus.writeData;
    end else if (state_q == ST_BUSY) begin
      if (access) state_d = ST_RESP;
      else        count_d = count_q - 4'd1;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      line_q  <= 128'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (access && !write_q) begin
        line_q <= {mem[{base, 2'd3}], mem[{base, 2'd2}], mem[{base, 2'd1}], mem[{base, 2'd0}]};
      end
    end
  end

  // Reset on the commit edge suppresses the write, so an aborted write never lands
  always_ff @(posedge clock) begin
    if (!reset && access && write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

`ifdef LINE_FILL_MEMORY_PATTERN_INIT_EN
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
  end
`else
  // Contents stay undefined until written.
`endif

  assign bus.ready     = (state_q != ST_BUSY);
  assign bus.lineValid = (state_q == ST_RESP) && !write_q;
  assign bus.writeDone = (state_q == ST_RESP) && write_q;
  assign bus.lineOut   = line_q;
endmodule

// File: tb/tb_line_fill_memory.sv
// tb/tb_line_fill_memory.sv - self-checking bench for line_fill_memory (LATENCY 4 and LATENCY 1 instances)
module tb_line_fill_memory;
  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  logic clk;
  logic rst;

  line_fill_memory_if #(.ADDR_W(15)) b0 ();
  line_fill_memory_if #(.ADDR_W(15)) b1 ();

  line_fill_memory #(.LATENCY(LAT0), .ADDR_W(15)) dut0 (.clock(clk), .reset(rst), .bus(b0));
  line_fill_memory #(.LATENCY(LAT1), .ADDR_W(15)) dut1 (.clock(clk), .reset(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [14:0]  addr;
    logic [31:0]  data;
    logic [127:0] exp_line;
  } vec_t;

  vec_t         tbl[$];
  logic [31:0]  mdl [int];
  int           passed;
  int           total;
  int           lat, busy, n, gap, lv_cnt, wd_cnt, b;
  bit           ok, wr;
  logic [127:0] line;
  logic [14:0]  a;
  logic [31:0]  d;
  int           regions [6] = '{0, 4, 16, 256, 4660, 32764};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic drive(input int sel, input bit r, input bit w, input logic [14:0] ad, input logic [31:0] dt);
    if (sel == 0) begin
      b0.req = r; b0.reqWrite = w; b0.reqAddress = ad; b0.writeData = dt;
    end else begin
      b1.req = r; b1.reqWrite = w; b1.reqAddress = ad; b1.writeData = dt;
    end
  endtask

  task automatic idle(input int sel);
    drive(sel, 1'b0, 1'($urandom), 15'($urandom), $urandom);
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? b0.ready : b1.ready;
  endfunction

  function automatic logic pulse(input int sel);
    return (sel == 0) ? (b0.lineValid | b0.writeDone) : (b1.lineValid | b1.writeDone);
  endfunction

  // Called on a falling edge; returns on the falling edge inside the response cycle.
  task automatic op(input int sel, input bit w, input logic [14:0] ad, input logic [31:0] dt,
                    output logic [127:0] ln, output int lt, output int bz, output bit kind_ok);
    int k;
    k = 0;
    while (!rdy(sel) && k < 40) begin @(negedge clk); k++; end
    drive(sel, 1'b1, w, ad, dt);
    @(negedge clk);
    idle(sel);
    lt = 0;
    bz = 0;
    while (!pulse(sel) && lt < 40) begin
      if (!rdy(sel)) bz++;
      @(negedge clk);
      lt++;
    end
    if (sel == 0) begin
      kind_ok = w ? (b0.writeDone && !b0.lineValid) : (b0.lineValid && !b0.writeDone);
      ln = b0.lineOut;
    end else begin
      kind_ok = w ? (b1.writeDone && !b1.lineValid) : (b1.lineValid && !b1.writeDone);
      ln = b1.lineOut;
    end
  endtask

  function automatic logic [127:0] model_line(input int addr);
    int bs;
    bs = addr & ~3;
    return {mdl[bs + 3], mdl[bs + 2], mdl[bs + 1], mdl[bs]};
  endfunction

  function automatic bit line_known(input int addr);
    int bs;
    bs = addr & ~3;
    return mdl.exists(bs) && mdl.exists(bs + 1) && mdl.exists(bs + 2) && mdl.exists(bs + 3);
  endfunction

  initial begin
    passed = 0;
    total  = 0;
    tbl.push_back('{1'b0, 15'h0005, 32'h0, 128'h00000007_00000006_00000005_00000004});
    tbl.push_back('{1'b1, 15'h1234, 32'hDEADBEEF, 128'h0});
    tbl.push_back('{1'b0, 15'h1236, 32'h0, 128'h00001237_00001236_00001235_DEADBEEF});
    tbl.push_back('{1'b0, 15'h0013, 32'h0, 128'h00000013_00000012_00000011_00000010});
    tbl.push_back('{1'b0, 15'h7FFE, 32'h0, 128'h00007FFF_00007FFE_00007FFD_00007FFC});
    tbl.push_back('{1'b1, 15'h0006, 32'h0000CAFE, 128'h0});
    tbl.push_back('{1'b0, 15'h0004, 32'h0, 128'h00000007_0000CAFE_00000005_00000004});
    tbl.push_back('{1'b1, 15'h0006, 32'h00000006, 128'h0});

    rst = 1'b1;
    idle(0);
    idle(1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 128'(b0.ready), 128'd1);
    chk("rst_lineValid", 128'(b0.lineValid), 128'd0);
    chk("rst_writeDone", 128'(b0.writeDone), 128'd0);
    chk("rst_lineOut", b0.lineOut, 128'd0);
    chk("rst1_ready", 128'(b1.ready), 128'd1);
    chk("rst1_lineOut", b1.lineOut, 128'd0);

    // Preload the test regions with mem[i] = i so the default build has known data
    foreach (regions[r]) begin
      for (int j = 0; j < 4; j++) begin
        op(0, 1'b1, 15'(regions[r] + j), 32'(regions[r] + j), line, lat, busy, ok);
        chk_i("pre_lat", lat, LAT0);
        chk_i("pre_kind", int'(ok), 1);
        mdl[regions[r] + j] = 32'(regions[r] + j);
      end
    end

    foreach (tbl[i]) begin
      op(0, tbl[i].wr, tbl[i].addr, tbl[i].data, line, lat, busy, ok);
      chk_i($sformatf("tbl%0d_lat", i), lat, LAT0);
      chk_i($sformatf("tbl%0d_ready_low", i), busy, LAT0);
      chk_i($sformatf("tbl%0d_kind", i), int'(ok), 1);
      if (tbl[i].wr) mdl[int'(tbl[i].addr)] = tbl[i].data;
      else chk($sformatf("tbl%0d_line", i), line, tbl[i].exp_line);
    end

    // Back-to-back: req held through BUSY, re-accepted in the RESP cycle
    drive(0, 1'b1, 1'b0, 15'h0000, 32'h0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 15'h0010, 32'h0);
    n = 0;
    while (!b0.lineValid && n < 40) begin @(negedge clk); n++; end
    chk("b2b_first_line", b0.lineOut, 128'h00000003_00000002_00000001_00000000);
    chk("b2b_ready_in_resp", 128'(b0.ready), 128'd1);
    @(negedge clk);
    idle(0);
    gap = 0;
    while (!b0.lineValid && gap < 40) begin @(negedge clk); gap++; end
    chk_i("b2b_gap", gap, LAT0);
    chk("b2b_second_word0", 128'(b0.lineOut[31:0]), 128'h00000010);
    chk("b2b_second_line", b0.lineOut, 128'h00000013_00000012_00000011_00000010);
    @(negedge clk);

    // Requests while busy are dropped
    drive(0, 1'b1, 1'b0, 15'h0004, 32'h0);
    @(negedge clk);
    lv_cnt = 0;
    wd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (!b0.ready) drive(0, 1'b1, 1'b1, 15'h0005, 32'hFFFFFFFF);
      else idle(0);
      @(negedge clk);
    end
    idle(0);
    for (int i = 0; i < 12; i++) begin
      lv_cnt += int'(b0.lineValid);
      wd_cnt += int'(b0.writeDone);
      @(negedge clk);
    end
    chk_i("busy_req_lineValid_count", lv_cnt, 1);
    chk_i("busy_req_writeDone_count", wd_cnt, 0);
    op(0, 1'b0, 15'h0005, 32'h0, line, lat, busy, ok);
    chk("busy_req_no_write", line, 128'h00000007_00000006_00000005_00000004);

    // Reset two cycles into a write aborts it
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 15'h0100, 32'h12345678);
    @(negedge clk);
    idle(0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 128'(b0.ready), 128'd1);
    chk("abort_lineOut_cleared", b0.lineOut, 128'd0);
    wd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      wd_cnt += int'(b0.writeDone);
      @(negedge clk);
    end
    chk_i("abort_no_writeDone", wd_cnt, 0);
    op(0, 1'b0, 15'h0100, 32'h0, line, lat, busy, ok);
    chk("abort_word0", 128'(line[31:0]), 128'h00000100);
    chk("abort_line", line, 128'h00000103_00000102_00000101_00000100);

    // Randomised traffic against the word-level model
    for (int k = 0; k < 60; k++) begin
      a  = 15'h2000 + 15'($urandom_range(0, 31));
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      b  = int'(a);
      if (!wr && !line_known(b)) wr = 1'b1;
      op(0, wr, a, d, line, lat, busy, ok);
      chk_i("rnd_lat", lat, LAT0);
      chk_i("rnd_kind", int'(ok), 1);
      if (wr) mdl[b] = d;
      else chk($sformatf("rnd_line_%h", a), line, model_line(b));
    end
    @(negedge clk);

    // LATENCY=1 instance, top-of-memory line
    for (int j = 0; j < 4; j++) begin
      op(1, 1'b1, 15'(32764 + j), 32'(32764 + j), line, lat, busy, ok);
      chk_i("l1_pre_lat", lat, LAT1);
    end
    op(1, 1'b0, 15'h7FFF, 32'h0, line, lat, busy, ok);
    chk_i("l1_lat", lat, LAT1);
    chk_i("l1_ready_low", busy, LAT1);
    chk_i("l1_kind", int'(ok), 1);
    chk("l1_line", line, 128'h00007FFF_00007FFE_00007FFD_00007FFC);
    @(negedge clk);
    chk("l1_lineOut_held", b1.lineOut, 128'h00007FFF_00007FFE_00007FFD_00007FFC);
    chk("l1_pulse_one_cycle", 128'(b1.lineValid), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
